// File: rtl/pll_rst_seq.sv
// Staggered per-domain reset sequencer driven by a filtered, synchronized PLL lock.
// Define PLL_RETRY_EN to add the lock-timeout PLL re-reset (pll_rst_req / retry_cnt).
module pll_rst_seq #(
    parameter int unsigned NUM_STAGES   = 4,
    parameter int unsigned LOCK_FILT    = 16,
    parameter int unsigned STAGE_GAP    = 8,
    parameter int unsigned LOCK_TIMEOUT = 65536,
    parameter int unsigned RST_PULSE    = 32
) (
    input  logic                  sys_clk,
    input  logic                  rst_n,
    input  logic                  locked,
    output logic [NUM_STAGES-1:0] stage_rst_n,
    output logic                  sys_ready,
    output logic                  lock_lost,
    output logic [7:0]            lock_loss_cnt,
    output logic                  pll_rst_req,
    output logic [3:0]            retry_cnt
);

    localparam int unsigned MAX_A = (NUM_STAGES > LOCK_FILT) ? NUM_STAGES : LOCK_FILT;
    localparam int unsigned MAX_B = (STAGE_GAP > MAX_A) ? STAGE_GAP : MAX_A;
    localparam int unsigned MAX_C = (LOCK_TIMEOUT > MAX_B) ? LOCK_TIMEOUT : MAX_B;
    localparam int unsigned MAX_P = (RST_PULSE > MAX_C) ? RST_PULSE : MAX_C;
    localparam int unsigned CNT_W = $clog2(MAX_P) + 1;

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        FILTER    = 3'd1,
        RELEASE   = 3'd2,
        RUN       = 3'd3
`ifdef PLL_RETRY_EN
        ,
        PLL_RST   = 3'd4
`endif
    } state_e;

    state_e                  state_q, state_d;
    logic                    sync1_q, locked_s_q;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [NUM_STAGES-1:0]   stage_q, stage_d, stage_shift;
    logic                    ready_q, ready_d;
    logic                    lost_q, lost_d;
    logic [7:0]              loss_cnt_q, loss_cnt_d;
`ifdef PLL_RETRY_EN
    logic [CNT_W-1:0]        tmo_q, tmo_d;
    logic                    req_q, req_d;
    logic [3:0]              retry_q, retry_d;
`endif

    // Two-flop synchronizer for the asynchronous lock input
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= 1'b0;
            locked_s_q <= 1'b0;
        end else begin
            sync1_q    <= locked;
            locked_s_q <= sync1_q;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= WAIT_LOCK;
            cnt_q      <= '0;
            stage_q    <= '0;
            ready_q    <= 1'b0;
            lost_q     <= 1'b0;
            loss_cnt_q <= '0;
`ifdef PLL_RETRY_EN
            tmo_q      <= '0;
            req_q      <= 1'b0;
            retry_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            stage_q    <= stage_d;
            ready_q    <= ready_d;
            lost_q     <= lost_d;
            loss_cnt_q <= loss_cnt_d;
`ifdef PLL_RETRY_EN
            tmo_q      <= tmo_d;
            req_q      <= req_d;
            retry_q    <= retry_d;
`endif
        end
    end

    // Thermometer shift: the next stage can only come out after all lower ones
    assign stage_shift = NUM_STAGES'({stage_q, 1'b1});

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stage_d    = stage_q;
        ready_d    = ready_q;
        lost_d     = 1'b0;
        loss_cnt_d = loss_cnt_q;
`ifdef PLL_RETRY_EN
        tmo_d      = tmo_q;
        req_d      = 1'b0;
        retry_d    = retry_q;
`endif
        case (state_q)
            WAIT_LOCK: begin
                stage_d = '0;
                ready_d = 1'b0;
                if (locked_s_q) begin
                    state_d = FILTER;
                    cnt_d   = '0;
                end
            end
            FILTER: begin
                if (!locked_s_q) begin
                    state_d = WAIT_LOCK;
                end else if (cnt_q == CNT_W'(LOCK_FILT - 1)) begin
                    stage_d = NUM_STAGES'(1);
                    cnt_d   = '0;
                    state_d = stage_d[NUM_STAGES-1] ? RUN : RELEASE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RELEASE, RUN: begin
                if (!locked_s_q) begin
                    state_d = WAIT_LOCK;
                    stage_d = '0;
                    ready_d = 1'b0;
                    lost_d  = 1'b1;
                    if (loss_cnt_q != 8'hFF) loss_cnt_d = loss_cnt_q + 8'd1;
                end else if (state_q == RUN) begin
                    ready_d = 1'b1;
                end else if (cnt_q == CNT_W'(STAGE_GAP - 1)) begin
                    stage_d = stage_shift;
                    cnt_d   = '0;
                    if (stage_shift[NUM_STAGES-1]) state_d = RUN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef PLL_RETRY_EN
            PLL_RST: begin
                stage_d = '0;
                ready_d = 1'b0;
                req_d   = 1'b1;
                if (cnt_q == CNT_W'(RST_PULSE - 1)) begin
                    req_d   = 1'b0;
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                    tmo_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            default: state_d = WAIT_LOCK;
        endcase
`ifdef PLL_RETRY_EN
        // Lock timeout only ticks while still trying to reach RELEASE
        if (state_q == WAIT_LOCK || state_q == FILTER) begin
            if (state_d == RELEASE || state_d == RUN) begin
                tmo_d = '0;
            end else if (tmo_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                state_d = PLL_RST;
                stage_d = '0;
                cnt_d   = '0;
                tmo_d   = '0;
                req_d   = 1'b1;
                if (retry_q != 4'hF) retry_d = retry_q + 4'd1;
            end else begin
                tmo_d = tmo_q + CNT_W'(1);
            end
        end
`endif
    end

    assign stage_rst_n   = stage_q;
    assign sys_ready     = ready_q;
    assign lock_lost     = lost_q;
    assign lock_loss_cnt = loss_cnt_q;
`ifdef PLL_RETRY_EN
    assign pll_rst_req   = req_q;
    assign retry_cnt     = retry_q;
`else
    assign pll_rst_req   = 1'b0;
    assign retry_cnt     = 4'd0;
`endif

endmodule
